ram_dp_be: RTL and testbench

Parametrised simple dual-port synchronous RAM with per-byte write enables and a selectable read-during-write mode. It also has a hardware clear sequencer that zeroes the whole array after reset or on request. It is the successor to the team's 32x32 single-port RAM and is used as register-file, scratchpad and buffer storage in datapath blocks. Write and read ports are independent, both in the single clock domain.

---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_be_merge.sv | 22 ++
 rtl/ram_dp_be.sv | 113 +++++++++++
 tb/tb_ram_dp_be.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-enable dual-port RAM.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic int lane_count(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/ram_be_merge.sv
// Byte-lane merge: enabled lanes come from new_data, the rest from old_word.
module ram_be_merge
  import ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  localparam int LANES = lane_count(DATA_W, BYTE_W)
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_data,
  input  logic [LANES-1:0]  be,
  output logic [DATA_W-1:0] merged
);

  always_comb begin
    merged = old_word;
    for (int k = 0; k < LANES; k++) begin
      if (be[k]) merged[k*BYTE_W +: BYTE_W] = new_data[k*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte enables, selectable read-during-write mode
// and a sequencer that zeroes the array after reset or on clr_req.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int BYTE_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int RDW_MODE = RDW_READ_FIRST,
  localparam int LANES   = lane_count(DATA_W, BYTE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [LANES-1:0]  w_be,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  input  logic              clr_req,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept, w_hit, r_hit, w_fire, r_fire, bypass;
  logic [DATA_W-1:0] w_old, w_merged, r_word;

  assign busy   = (state == ST_CLEAR);
  // A clr_req edge swallows any access presented alongside it.
  assign accept = (state == ST_READY) && !clr_req;
  assign w_hit  = ({1'b0, w_addr} < DEPTH_X);
  assign r_hit  = ({1'b0, r_addr} < DEPTH_X);
  assign w_fire = accept && w_en && w_hit;
  assign r_fire = accept && r_en;
  assign w_old  = w_hit ? mem[w_addr] : '0;
  assign r_word = r_hit ? mem[r_addr] : '0;
  assign bypass = (RDW_MODE == RDW_WRITE_FIRST) && w_fire && (w_addr == r_addr);

  ram_be_merge #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W)
  ) u_merge (
    .old_word (w_old),
    .new_data (w_data),
    .be       (w_be),
    .merged   (w_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      ST_CLEAR: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == LAST_ADDR) begin
          state_nxt = ST_READY;
          ptr_nxt   = '0;
        end
      end
      ST_READY: begin
        if (clr_req) begin
          state_nxt = ST_CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Array has no reset; the clear sequencer is what zeroes it.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) mem[ptr] <= '0;
    else if (w_fire)       mem[w_addr] <= w_merged;
  end

  // r_valid is a one-cycle pulse: high exactly for the cycle after an accepted
  // r_en, qualifying r_data. There is no ready; the consumer must take it then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (r_fire) begin
      r_data  <= bypass ? w_merged : r_word;
      r_valid <= 1'b1;
    end else begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench: default read-first RAM, a write-first twin and a DEPTH=24 variant
// share one stimulus stream; each output is checked against hand-computed values.
module tb_ram_dp_be;

  logic        clk;
  logic        rst_n;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_be;
  logic        r_en;
  logic [4:0]  r_addr;
  logic        clr_req;

  logic [31:0] r_data0, r_data1, r_data2;
  logic        r_valid0, r_valid1, r_valid2;
  logic        busy0, busy1, busy2;

  int n_checks = 0;
  int n_fails  = 0;
  int n0, n1, n2;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_dp_be dut0 (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .w_be(w_be), .r_en(r_en), .r_addr(r_addr), .r_data(r_data0),
    .r_valid(r_valid0), .clr_req(clr_req), .busy(busy0)
  );

  ram_dp_be #(.RDW_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .w_be(w_be), .r_en(r_en), .r_addr(r_addr), .r_data(r_data1),
    .r_valid(r_valid1), .clr_req(clr_req), .busy(busy1)
  );

  ram_dp_be #(.DEPTH(24)) dut2 (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .w_be(w_be), .r_en(r_en), .r_addr(r_addr), .r_data(r_data2),
    .r_valid(r_valid2), .clr_req(clr_req), .busy(busy2)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_en    = 1'b0;
    r_en    = 1'b0;
    clr_req = 1'b0;
    w_be    = 4'h0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    w_en = 1'b1; w_addr = a; w_data = d; w_be = be;
    tick();
    idle();
  endtask

  task automatic rd(input logic [4:0] a);
    r_en = 1'b1; r_addr = a;
    tick();
    idle();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Edges until each busy drops, counted from the current sample point.
  task automatic measure_busy(output int c0, output int c1, output int c2);
    c0 = -1; c1 = -1; c2 = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (!busy0 && c0 < 0) c0 = k;
      if (!busy1 && c1 < 0) c1 = k;
      if (!busy2 && c2 < 0) c2 = k;
      if (c0 >= 0 && c1 >= 0 && c2 >= 0) break;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    w_addr = '0; w_data = '0; r_addr = '0;
    #12;
    check("rst_busy0", 32'(busy0), 32'd1);
    check("rst_busy2", 32'(busy2), 32'd1);
    check("rst_rvalid0", 32'(r_valid0), 32'd0);
    check("rst_rdata0", r_data0, 32'h0);

    rst_n = 1'b1;
    measure_busy(n0, n1, n2);
    check("init_busy_cycles0", n0, 32'd32);
    check("init_busy_cycles1", n1, 32'd32);
    check("init_busy_cycles2", n2, 32'd24);

    // Freshly cleared array reads zero with a one-cycle valid.
    rd(5'd0);
    check("rd0_data", r_data0, 32'h0);
    check("rd0_valid", 32'(r_valid0), 32'd1);
    rd(5'd17);
    check("rd17_data", r_data0, 32'h0);
    check("rd17_valid", 32'(r_valid0), 32'd1);
    rd(5'd31);
    check("rd31_data", r_data0, 32'h0);
    check("rd31_valid", 32'(r_valid0), 32'd1);
    tick();
    check("noread_valid", 32'(r_valid0), 32'd0);
    check("noread_data", r_data0, 32'h0);

    // Byte enables.
    wr(5'd5, 32'hAABBCCDD, 4'b1111);
    wr(5'd5, 32'h11223344, 4'b0101);
    rd(5'd5);
    check("be_merge0", r_data0, 32'hAA22CC44);
    check("be_merge1", r_data1, 32'hAA22CC44);
    check("be_merge2", r_data2, 32'hAA22CC44);
    wr(5'd5, 32'hDEADBEEF, 4'b0000);
    rd(5'd5);
    check("be_zero", r_data0, 32'hAA22CC44);

    // Read-during-write, same address.
    wr(5'd9, 32'h0000FFFF, 4'b1111);
    w_en = 1'b1; w_addr = 5'd9; w_data = 32'h12345678; w_be = 4'b1111;
    r_en = 1'b1; r_addr = 5'd9;
    tick();
    idle();
    check("rdw_read_first", r_data0, 32'h0000FFFF);
    check("rdw_write_first", r_data1, 32'h12345678);
    rd(5'd9);
    check("rdw_after0", r_data0, 32'h12345678);
    check("rdw_after1", r_data1, 32'h12345678);
    w_en = 1'b1; w_addr = 5'd9; w_data = 32'hAABBCCDD; w_be = 4'b0011;
    r_en = 1'b1; r_addr = 5'd9;
    tick();
    idle();
    check("rdw_part_rf", r_data0, 32'h12345678);
    check("rdw_part_wf", r_data1, 32'h1234CCDD);

    // Different addresses on one edge are independent.
    w_en = 1'b1; w_addr = 5'd3; w_data = 32'hCAFEF00D; w_be = 4'b1111;
    r_en = 1'b1; r_addr = 5'd5;
    tick();
    idle();
    check("indep_rd0", r_data0, 32'hAA22CC44);
    check("indep_rd1", r_data1, 32'hAA22CC44);
    rd(5'd3);
    check("indep_wr", r_data0, 32'hCAFEF00D);

    // Out-of-range write/read on the DEPTH=24 instance.
    wr(5'd30, 32'h55555555, 4'b1111);
    rd(5'd30);
    check("oor_rd_data2", r_data2, 32'h0);
    check("oor_rd_valid2", 32'(r_valid2), 32'd1);
    check("inr_rd_data0", r_data0, 32'h55555555);
    rd(5'd6);
    check("oor_noalias2", r_data2, 32'h0);

    // Fill, then clear with accesses hammering during busy.
    for (int a = 0; a < 32; a++) wr(5'(a), 32'hFFFFFFFF, 4'b1111);
    rd(5'd31);
    check("fill_rd", r_data0, 32'hFFFFFFFF);
    clr_req = 1'b1;
    w_en = 1'b1; w_addr = 5'd0; w_data = 32'h12345678; w_be = 4'b1111;
    r_en = 1'b1; r_addr = 5'd0;
    tick();
    clr_req = 1'b0;
    check("clr_busy", 32'(busy0), 32'd1);
    check("clr_edge_valid", 32'(r_valid0), 32'd0);
    n0 = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      check("clr_rvalid0", 32'(r_valid0), 32'd0);
      check("clr_rvalid1", 32'(r_valid1), 32'd0);
      if (!busy0) begin
        n0 = k;
        break;
      end
    end
    idle();
    check("clr_busy_cycles0", n0, 32'd32);
    check("clr_busy_state1", 32'(busy1), 32'd0);
    r_en = 1'b1;
    for (int a = 0; a < 32; a++) begin
      r_addr = 5'(a);
      tick();
      check("sweep0", r_data0, 32'h0);
      check("sweep1", r_data1, 32'h0);
    end
    idle();

    // Async reset while READY with a valid read outstanding.
    wr(5'd7, 32'h87654321, 4'b1111);
    rd(5'd7);
    check("pre_rst_data", r_data0, 32'h87654321);
    check("pre_rst_valid", 32'(r_valid0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data", r_data0, 32'h0);
    check("async_rst_valid", 32'(r_valid0), 32'd0);
    check("async_rst_busy", 32'(busy0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    measure_busy(n0, n1, n2);
    check("rerst_cycles0", n0, 32'd32);
    check("rerst_cycles2", n2, 32'd24);
    rd(5'd7);
    check("rerst_cleared", r_data0, 32'h0);

    // Reset in the middle of a clr_req clear.
    wr(5'd2, 32'h0BADF00D, 4'b1111);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("midclr_busy", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midclr_rst_busy", 32'(busy0), 32'd1);
    check("midclr_rst_valid", 32'(r_valid0), 32'd0);
    check("midclr_rst_data", r_data0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    measure_busy(n0, n1, n2);
    check("midclr_cycles0", n0, 32'd32);
    check("midclr_cycles1", n1, 32'd32);
    check("midclr_cycles2", n2, 32'd24);
    rd(5'd2);
    check("midclr_cleared", r_data0, 32'h0);
    check("midclr_valid", 32'(r_valid0), 32'd1);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
